// File: rtl/serial_frame_pkg.sv
// Shared types and sizing helpers for the serial frame controller.
package serial_frame_pkg;

  localparam int DEF_PORT_W = 2;
  localparam int DEF_CNT_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    PORT,
    COUNT,
    XMIT,
    DONE
  } frame_state_t;

  // Bit counter must reach the longer of the two header fields.
  function automatic int bit_cnt_width(input int port_w, input int cnt_w);
    int longest;
    longest = (port_w > cnt_w) ? port_w : cnt_w;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/sipo_shift.sv
// MSB-first serial-in/parallel-out register, enable-gated, async active-low clear.
module sipo_shift #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= (q << 1) | W'(din);
    end
  end

endmodule

// File: rtl/serial_frame_controller.sv
// Frame sequencer: start bit, port address, bit count, then routes payload bits
// onto the selected port and pulses Done at frame end.
module serial_frame_controller
  import serial_frame_pkg::*;
#(
  parameter int PORT_W = DEF_PORT_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clkEn,
  input  logic                 SerIn,
  output logic [2**PORT_W-1:0] P,
  output logic                 SerOutValid,
  output logic                 Done,
  output logic [CNT_W-1:0]     CntOut
);

  localparam int BCW = bit_cnt_width(PORT_W, CNT_W);

  frame_state_t      state, next_state;
  logic [BCW-1:0]    bit_cnt;
  logic [PORT_W-1:0] port_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  count_full;
  logic              port_shift;
  logic              count_shift;

  sipo_shift #(.W(PORT_W)) u_port_reg (
    .clk (clk),
    .rst (rst),
    .en  (port_shift),
    .din (SerIn),
    .q   (port_q)
  );

  sipo_shift #(.W(CNT_W)) u_count_reg (
    .clk (clk),
    .rst (rst),
    .en  (count_shift),
    .din (SerIn),
    .q   (count_q)
  );

  // Value the count register will hold once the current bit is shifted in.
  assign count_full = (count_q << 1) | CNT_W'(SerIn);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    port_shift  = 1'b0;
    count_shift = 1'b0;
    if (clkEn) begin
      case (state)
        IDLE: begin
          if (!SerIn) next_state = PORT;
        end
        PORT: begin
          port_shift = 1'b1;
          if (bit_cnt == BCW'(PORT_W - 1)) next_state = COUNT;
        end
        COUNT: begin
          count_shift = 1'b1;
          if (bit_cnt == BCW'(CNT_W - 1)) begin
            next_state = (count_full != '0) ? XMIT : DONE;
          end
        end
        XMIT: begin
          if (remaining <= CNT_W'(1)) next_state = DONE;
        end
        DONE: begin
          next_state = IDLE;
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

  // Field bit counter and the payload down-counter loaded at the end of COUNT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt   <= '0;
      remaining <= '0;
    end else if (clkEn) begin
      case (state)
        IDLE: begin
          bit_cnt <= '0;
        end
        PORT: begin
          bit_cnt <= (next_state == COUNT) ? '0 : bit_cnt + BCW'(1);
        end
        COUNT: begin
          bit_cnt <= bit_cnt + BCW'(1);
          if (next_state != COUNT) remaining <= count_full;
        end
        XMIT: begin
          if (remaining != '0) remaining <= remaining - CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign SerOutValid = (state == XMIT) && clkEn;
  assign Done        = (state == DONE);
  assign CntOut      = (state == COUNT) ? count_q : remaining;

  always_comb begin
    P = '0;
    if (SerOutValid) P[port_q] = SerIn;
  end

endmodule
